fp_sub_seq: RTL and testbench
=============================

FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 SHALL have parameter ALIGN_LIMIT, default 26: if the exponent difference is ≥ this value, the smaller operand is treated as zero.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-006 SHALL have ports data1 and data2, input, 32 bits each: IEEE-754 single-precision operands; the result is data1 - data2.
REQ-007 SHALL have port out_valid, output, 1 bit: result, overflow and underflow are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port result, output, 32 bits: IEEE-754 difference.
REQ-010 SHALL have ports overflow and underflow, output, 1 bit each: exception flags, qualified by out_valid.

Function
REQ-011 SHALL implement the states IDLE, ALIGN, SUB, NORM and DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE; in_valid && in_ready registers data1/data2 and moves to ALIGN.
REQ-013 ALIGN SHALL:
- invert the sign of data2;
- treat an operand with exponent 0 as zero;
- select the larger exponent;
- right-shift the 24-bit mantissa (implicit 1) of the smaller operand by the exponent difference, or zero it if the difference ≥ ALIGN_LIMIT;
- go to SUB.
REQ-014 SUB SHALL add the magnitudes when the effective signs are equal; otherwise it SHALL subtract the smaller from the larger, taking the sign of the larger, into a 25-bit magnitude.
REQ-015 In SUB:
- bit 24 set: shift right 1, exponent +1, go to DONE;
- magnitude zero: result 0x00000000, flags 0, go to DONE;
- bit 23 set: go to DONE;
- otherwise: go to NORM.
REQ-016 NORM SHALL shift the mantissa left 1 bit per cycle and decrement the exponent by 1, leaving when bit 23 is set.
REQ-017 If the exponent reaches 0 in NORM, the block SHALL output signed zero {sign, 31'b0}, set underflow=1 and go to DONE.
REQ-018 An exponent of 8'hFF after normalization SHALL produce {sign, 8'hFF, 23'b0} with overflow=1.
REQ-019 There SHALL be no rounding; the mantissa SHALL be truncated, with result[22:0] = mantissa[22:0].
REQ-020 DONE SHALL assert out_valid and hold result and flags stable until out_valid && out_ready, then go to IDLE; there is no bypass from DONE to accept.
REQ-021 Latency from the accept edge to the first out_valid SHALL be 3 + k cycles, where k is the number of NORM cycles (0–23).

Reset
REQ-022 rst SHALL force, asynchronously:
- state = IDLE;
- out_valid = 0, result = 0, overflow = 0, underflow = 0;
- in_ready = 1 after release.
REQ-023 Reset in any state, including mid-NORM, SHALL discard the operation; no out_valid SHALL follow it.

Configuration
REQ-024 With FP_SUB_SEQ_LZC_EN defined, NORM SHALL take exactly 1 cycle, performing the full left shift and exponent decrement from a leading-zero count (underflow if the count ≥ the exponent).
REQ-025 Without FP_SUB_SEQ_LZC_EN, NORM SHALL operate at 1 bit per cycle per REQ-016.
REQ-026 Results and flags SHALL be identical in both configurations; only latency differs.

Structure
REQ-027 The shared package fp_pkg SHALL hold:
- the fp32_t struct (sign, exp[7:0], mant[22:0]);
- the state enum;
- the constants EXP_BIAS = 127 and EXP_MAX = 8'hFF.
REQ-028 The sub-module fp_lzc (24-bit leading-zero counter, combinational) SHALL be instantiated only when FP_SUB_SEQ_LZC_EN is defined.

Verification
REQ-029 The bench SHALL check: 0x40400000 - 0x3F800000 -> result 0x40000000, flags 0, out_valid 3 cycles after accept.
REQ-030 The bench SHALL check: 0x3F800000 - 0x3F800000 -> result 0x00000000, flags 0, latency 3.
REQ-031 The bench SHALL check: 0x3FC00000 - 0x3F800000 -> result 0x3F000000, latency 4 in both configurations.
REQ-032 The bench SHALL check: 0x7F7FFFFF - 0xFF7FFFFF -> result 0x7F800000, overflow=1; 0x00800000 - 0x00C00000 -> result 0x80000000, underflow=1.
REQ-033 The bench SHALL check: out_ready held low 5 cycles in DONE -> out_valid, result and flags stable, in_ready=0; accept on the 6th cycle, then in_ready=1 the next cycle.
REQ-034 The bench SHALL check: rst pulsed mid-NORM (0x3F800001 - 0x3F800000) -> out_valid=0 and all outputs 0 immediately, in_ready=1 after release, no stale result.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential single-precision subtractor.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    DONE
  } state_t;

  localparam int         EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  // A biased exponent at or beyond all-ones cannot be represented as a finite value.
  function automatic logic is_ovf(input logic [8:0] e);
    return e >= {1'b0, EXP_MAX};
  endfunction

  // Packs sign/exponent/fraction, saturating to a signed infinity on overflow.
  function automatic fp32_t pack_fp(input logic sign, input logic [8:0] e, input logic [22:0] m);
    fp32_t r;
    r.sign = sign;
    r.exp  = e[7:0];
    r.mant = m;
    if (is_ovf(e)) begin
      r.exp  = EXP_MAX;
      r.mant = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 24-bit leading-zero counter (combinational). Returns 24 for an all-zero input.
module fp_lzc (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_sub_seq.sv
// Sequential IEEE-754 single-precision subtractor: result = data1 - data2.
// Truncating (no rounding); operands with exponent 0 are treated as zero.
// Optional macro FP_SUB_SEQ_LZC_EN: normalise in one NORM cycle using a
// leading-zero count instead of one bit per cycle. Results are identical.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// ALIGN | invert data2 sign, shift smaller mantissa to the larger exponent
// SUB   | signed-magnitude add/subtract, handle carry-out / zero / normal
// NORM  | left-normalise the magnitude, underflow to signed zero
// DONE  | hold result and flags with out_valid until out_ready
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter int ALIGN_LIMIT = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned ALIGN_LIM_U = ALIGN_LIMIT;

  state_t      state;
  fp32_t       op_a, op_b;
  logic [8:0]  exp_r;
  logic [23:0] m_big, m_small, mant_r;
  logic        s_big, s_small, sign_r;

  logic [23:0] a_mant, b_mant, small_raw, al_big, al_small;
  logic [7:0]  al_exp, al_diff;
  logic        al_big_sign, al_small_sign;
  logic [24:0] mag;
  logic        sub_sign;
  logic [8:0]  norm_exp;
  logic [23:0] norm_mant;
  logic        norm_uf, norm_done;

  // Blocked while reset is held so nothing is accepted before release.
  assign in_ready = (state == IDLE) && !rst;

  // Alignment: the operand with the larger exponent keeps its mantissa; the other
  // is shifted down by the difference, or dropped once it would be shifted away.
  always_comb begin
    a_mant        = (op_a.exp == 8'd0) ? 24'd0 : {1'b1, op_a.mant};
    b_mant        = (op_b.exp == 8'd0) ? 24'd0 : {1'b1, op_b.mant};
    al_exp        = op_a.exp;
    al_big        = a_mant;
    al_big_sign   = op_a.sign;
    small_raw     = b_mant;
    al_small_sign = ~op_b.sign;
    al_diff       = op_a.exp - op_b.exp;
    if (op_b.exp > op_a.exp) begin
      al_exp        = op_b.exp;
      al_big        = b_mant;
      al_big_sign   = ~op_b.sign;
      small_raw     = a_mant;
      al_small_sign = op_a.sign;
      al_diff       = op_b.exp - op_a.exp;
    end
    al_small = ({24'd0, al_diff} >= ALIGN_LIM_U) ? 24'd0 : (small_raw >> al_diff);
  end

  // Signed-magnitude combine; on unlike signs the larger magnitude sets the sign.
  always_comb begin
    sub_sign = s_big;
    if (s_big == s_small) begin
      mag = {1'b0, m_big} + {1'b0, m_small};
    end else if (m_big >= m_small) begin
      mag = {1'b0, m_big - m_small};
    end else begin
      mag      = {1'b0, m_small - m_big};
      sub_sign = s_small;
    end
  end

`ifdef FP_SUB_SEQ_LZC_EN
  logic [4:0] lz;

  fp_lzc u_lzc (
    .value (mant_r),
    .count (lz)
  );

  // Full normalisation in one step; underflow when the shift eats the whole exponent.
  always_comb begin
    norm_exp  = exp_r - {4'd0, lz};
    norm_mant = mant_r << lz;
    norm_uf   = ({4'd0, lz} >= exp_r);
  end
`else
  // One-bit normalisation step; underflow as soon as the exponent hits zero.
  always_comb begin
    norm_exp  = exp_r - 9'd1;
    norm_mant = mant_r << 1;
    norm_uf   = (norm_exp == 9'd0);
  end
`endif

  assign norm_done = norm_mant[23];

  // Control FSM plus datapath registers; all outputs registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      exp_r     <= '0;
      m_big     <= '0;
      m_small   <= '0;
      s_big     <= 1'b0;
      s_small   <= 1'b0;
      mant_r    <= '0;
      sign_r    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= data1;
            op_b  <= data2;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          exp_r   <= {1'b0, al_exp};
          m_big   <= al_big;
          m_small <= al_small;
          s_big   <= al_big_sign;
          s_small <= al_small_sign;
          state   <= SUB;
        end
        SUB: begin
          underflow <= 1'b0;
          if (mag[24]) begin
            result   <= pack_fp(sub_sign, exp_r + 9'd1, mag[23:1]);
            overflow <= is_ovf(exp_r + 9'd1);
            state    <= DONE;
          end else if (mag == 25'd0) begin
            result   <= '0;
            overflow <= 1'b0;
            state    <= DONE;
          end else if (mag[23]) begin
            result   <= pack_fp(sub_sign, exp_r, mag[22:0]);
            overflow <= is_ovf(exp_r);
            state    <= DONE;
          end else begin
            sign_r <= sub_sign;
            mant_r <= mag[23:0];
            state  <= NORM;
          end
        end
        NORM: begin
          if (norm_uf) begin
            result    <= {sign_r, 31'b0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
            state     <= DONE;
          end else if (norm_done) begin
            result    <= pack_fp(sign_r, norm_exp, norm_mant[22:0]);
            overflow  <= is_ovf(norm_exp);
            underflow <= 1'b0;
            state     <= DONE;
          end else begin
            exp_r  <= norm_exp;
            mant_r <= norm_mant;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed-vector bench for fp_sub_seq with a behavioural reference model.
module tb_fp_sub_seq;
  import fp_pkg::*;

  localparam int LIM = 26;
`ifdef FP_SUB_SEQ_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif
  localparam logic [31:0] ONE = {1'b0, 8'(EXP_BIAS), 23'd0};

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
    logic        uf;
    int          lat_ser;
    int          lat_lzc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  exp_t        q[$];
  logic [31:0] last_res = '0;
  logic        last_ov = 1'b0;
  logic        last_uf = 1'b0;
  int          last_lat = 0;
  bit          first_seen = 1'b0;
  vec_t        vecs [14];

  fp_sub_seq #(.ALIGN_LIMIT(LIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact signed integer arithmetic on aligned (truncated) mantissas,
  // then normalise by plain multiply/divide by two.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int   ea, eb, e, ma, mb, sum, mag, k;
    logic s;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    ma = (ea == 0) ? 0 : (int'(x[22:0]) + (1 << 23));
    mb = (eb == 0) ? 0 : (int'(y[22:0]) + (1 << 23));
    e  = (ea > eb) ? ea : eb;
    ma = (e - ea >= LIM) ? 0 : (ma >> (e - ea));
    mb = (e - eb >= LIM) ? 0 : (mb >> (e - eb));
    sum = (x[31] ? -ma : ma) - (y[31] ? -mb : mb);
    r.ov = 1'b0;
    r.uf = 1'b0;
    r.acc = 0;
    r.res = '0;
    k = 0;
    if (sum != 0) begin
      s   = (sum < 0);
      mag = s ? -sum : sum;
      if (mag >= (1 << 24)) begin
        mag = mag / 2;
        e++;
      end
      while (mag < (1 << 23) && !r.uf) begin
        mag = mag * 2;
        e--;
        k++;
        if (e == 0) r.uf = 1'b1;
      end
      if (r.uf) r.res = {s, 31'b0};
      else if (e >= 255) begin
        r.res = {s, 8'hFF, 23'b0};
        r.ov  = 1'b1;
      end else r.res = {s, e[7:0], mag[22:0]};
    end
    r.lat = 3 + (LZC ? ((k > 0) ? 1 : 0) : k);
    return r;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    m = model(a, b);
    data1 = a;
    data2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    m.acc = cyc;
    in_valid = 1'b0;
    q.push_back(m);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t m;
    int   n;
    m = model(v.a, v.b);
    check($sformatf("v%0d_model_res", idx), m.res, v.res);
    check($sformatf("v%0d_model_lat", idx), m.lat, LZC ? v.lat_lzc : v.lat_ser);
    send(v.a, v.b);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_drain", idx), q.size(), 32'd0);
    check($sformatf("v%0d_result", idx), last_res, v.res);
    check($sformatf("v%0d_overflow", idx), 32'(last_ov), 32'(v.ov));
    check($sformatf("v%0d_underflow", idx), 32'(last_uf), 32'(v.uf));
    check($sformatf("v%0d_latency", idx), last_lat, LZC ? v.lat_lzc : v.lat_ser);
  endtask

  // Compare process: every cycle a result is presented, check it against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) first_seen = 1'b0;
      else if (out_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          check("result", result, q[0].res);
          check("overflow", 32'(overflow), 32'(q[0].ov));
          check("underflow", 32'(underflow), 32'(q[0].uf));
          if (!first_seen) begin
            first_seen = 1'b1;
            last_lat = cyc - q[0].acc;
            check("latency", last_lat, q[0].lat);
          end
          last_res = result;
          last_ov  = overflow;
          last_uf  = underflow;
          if (out_ready) begin
            void'(q.pop_front());
            first_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    vecs[0]  = '{32'h40400000, ONE,          32'h40000000, 1'b0, 1'b0, 3,  3};
    vecs[1]  = '{ONE,          ONE,          32'h00000000, 1'b0, 1'b0, 3,  3};
    vecs[2]  = '{32'h3FC00000, ONE,          32'h3F000000, 1'b0, 1'b0, 4,  4};
    vecs[3]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 3,  3};
    vecs[4]  = '{32'h00800000, 32'h00C00000, 32'h80000000, 1'b0, 1'b1, 4,  4};
    vecs[5]  = '{ONE,          32'hC0000000, 32'h40400000, 1'b0, 1'b0, 3,  3};
    vecs[6]  = '{ONE,          32'h40000000, 32'hBF800000, 1'b0, 1'b0, 4,  4};
    vecs[7]  = '{32'h40000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 3,  3};
    vecs[8]  = '{32'h4B800000, ONE,          32'h4B800000, 1'b0, 1'b0, 3,  3};
    vecs[9]  = '{ONE,          32'hBF800000, 32'h40000000, 1'b0, 1'b0, 3,  3};
    vecs[10] = '{32'h3F800001, ONE,          32'h34000000, 1'b0, 1'b0, 26, 4};
    vecs[11] = '{32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 4,  4};
    vecs[12] = '{32'h40A00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 4,  4};
    vecs[13] = '{ONE,          32'h3F000001, 32'h3F000000, 1'b0, 1'b0, 4,  4};

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-pressure: hold out_ready low for five presented cycles.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h40400000, ONE);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_wait", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", result, 32'h40000000);
      check("stall_flags", {30'd0, overflow, underflow}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_drained", q.size(), 32'd0);

    // Reset in the middle of normalisation.
    send(32'h3F800001, ONE);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {30'd0, overflow, underflow}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrst_no_stale", n, 32'd0);

    run_vec(10, vecs[10]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
